// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV32 instruction fetch. Owns the PC and feeds the IF/ID register
//            with a valid/ready handshake, redirect flush and ECALL halt.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 32'h0;
            out_inst_q    <= NOP_INST;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_inst_q    <= out_inst_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_inst_d    = out_inst_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;

        if (redirect) begin
            // Flush wins over any fetch or stall; out_pc deliberately holds.
            pc_d        = {redirect_pc[31:2], 2'b00};
            out_valid_d = 1'b0;
            out_inst_d  = NOP_INST;
            state_d     = RUN;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (!out_valid_q || out_ready) begin
                        out_valid_d   = 1'b1;
                        out_pc_d      = pc_q;
                        out_inst_d    = imem_inst;
                        pc_d          = pc_q + 32'd4;
                        fetch_count_d = fetch_count_q + 32'd1;
                        if (imem_inst == ECALL_INST || imem_inst == EBREAK_INST) begin
                            state_d = HALT;
                        end
                    end
                end
                HALT: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        out_inst_d  = NOP_INST;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    assign imem_addr    = pc_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_inst     = out_inst_q;
    assign halted       = (state_q == HALT);
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:63];
    int          n_checks;
    int          n_errors;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_inst    (imem_inst),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .halted       (halted),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    assign imem_inst = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
        mem[0]  = 32'h0050_0093;
        mem[1]  = 32'h0030_0113;
        mem[2]  = 32'h0000_0073;
        mem[16] = 32'h0010_0093;

        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        step(); step();
        check("rst_valid",  {31'h0, out_valid}, 32'h0);
        check("rst_addr",   imem_addr, 32'h0);
        check("rst_inst",   out_inst, C_NOP);
        check("rst_pc",     out_pc, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_count",  fetch_count, 32'h0);
        rst = 1'b0;

        // BOOT cycle, then first fetch at RESET_PC
        step();
        check("boot_valid", {31'h0, out_valid}, 32'h0);
        step();
        check("f0_valid", {31'h0, out_valid}, 32'h1);
        check("f0_pc",    out_pc, 32'h0);
        check("f0_inst",  out_inst, 32'h0050_0093);
        step();
        check("f1_pc",    out_pc, 32'h4);
        check("f1_inst",  out_inst, 32'h0030_0113);
        check("f1_count", fetch_count, 32'd2);

        // ECALL at 0x8 halts fetch
        step();
        check("ec_pc",     out_pc, 32'h8);
        check("ec_inst",   out_inst, 32'h0000_0073);
        check("ec_halted", {31'h0, halted}, 32'h1);
        check("ec_addr",   imem_addr, 32'hC);
        for (int i = 0; i < 10; i++) step();
        check("halt_valid", {31'h0, out_valid}, 32'h0);
        check("halt_inst",  out_inst, C_NOP);
        check("halt_count", fetch_count, 32'd3);
        check("halt_addr",  imem_addr, 32'hC);
        check("halt_still", {31'h0, halted}, 32'h1);

        do_redirect(32'h0);
        check("unhalt",     {31'h0, halted}, 32'h0);
        check("unhalt_adr", imem_addr, 32'h0);
        check("unhalt_vld", {31'h0, out_valid}, 32'h0);
        step();
        check("resume_pc",  out_pc, 32'h0);
        check("resume_vld", {31'h0, out_valid}, 32'h1);

        // Stall for 5 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("stall_pc",    out_pc, 32'h0);
        check("stall_inst",  out_inst, 32'h0050_0093);
        check("stall_addr",  imem_addr, 32'h4);
        check("stall_count", fetch_count, 32'd4);
        out_ready = 1'b1;
        step();
        check("rel_pc",    out_pc, 32'h4);
        check("rel_count", fetch_count, 32'd5);

        // Redirect while stalled with valid data
        out_ready = 1'b0;
        do_redirect(32'h40);
        check("rd_valid", {31'h0, out_valid}, 32'h0);
        check("rd_inst",  out_inst, C_NOP);
        check("rd_hold",  out_pc, 32'h4);
        step();
        check("rd_pc",    out_pc, 32'h40);
        check("rd_tinst", out_inst, 32'h0010_0093);
        check("rd_tvld",  {31'h0, out_valid}, 32'h1);

        // Misaligned target is aligned down and flagged stickily
        out_ready = 1'b1;
        check("mis_pre", {31'h0, misalign_err}, 32'h0);
        do_redirect(32'h42);
        check("mis_addr", imem_addr, 32'h40);
        check("mis_set",  {31'h0, misalign_err}, 32'h1);
        do_redirect(32'h80);
        check("mis_sticky", {31'h0, misalign_err}, 32'h1);
        step();
        check("al_pc",    out_pc, 32'h80);
        check("al_inst",  out_inst, 32'hA000_0020);
        check("al_count", fetch_count, 32'd7);

        // PC wrap at top of address space
        do_redirect(32'hFFFF_FFFC);
        step();
        check("wrap_pc",   out_pc, 32'hFFFF_FFFC);
        check("wrap_inst", out_inst, 32'hA000_003F);
        check("wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset mid-stream
        rst = 1'b1;
        #1;
        check("arst_valid", {31'h0, out_valid}, 32'h0);
        check("arst_addr",  imem_addr, 32'h0);
        check("arst_count", fetch_count, 32'h0);
        check("arst_mis",   {31'h0, misalign_err}, 32'h0);
        check("arst_inst",  out_inst, C_NOP);
        step();
        rst = 1'b0;

        // Redirect during BOOT
        do_redirect(32'h40);
        check("boot_rd_addr", imem_addr, 32'h40);
        check("boot_rd_vld",  {31'h0, out_valid}, 32'h0);
        step();
        check("boot_rd_pc",   out_pc, 32'h40);
        check("boot_rd_cnt",  fetch_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
